// File: rtl/mem_port_initiator.sv
// Load/store initiator for a memory_port responder: one request at a time, load-data extension,
// and optional splitting of misaligned HALF/WORD accesses into little-endian BYTE beats.
module mem_port_initiator #(
    parameter int unsigned SPLIT_MISALIGNED = 1
) (
    input  logic        clk,
    input  logic        rst,
    // core request side
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_width,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    // core response side
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    // memory_port initiator side
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_width,
    output logic [31:0] mem_data_wr,
    input  logic [31:0] mem_data_rd
);

    // memory_access_width_t encoding
    localparam logic [1:0] WidthByte = 2'd0;
    localparam logic [1:0] WidthHalf = 2'd1;
    localparam logic [1:0] WidthWord = 2'd2;

    typedef enum logic [1:0] {StIdle, StAccess, StSplit, StResp} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  width_q, width_d;
    logic        uns_q, uns_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  beat_q, beat_d;
    logic [31:0] result_q, result_d;
    logic        err_q, err_d;

    logic [31:0] lane;
    logic        last_beat;
    logic        misaligned;

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] w,
                                           input logic uns);
        logic [31:0] r;
        if (w == WidthByte) begin
            r = {{24{d[7] & ~uns}}, d[7:0]};
        end else if (w == WidthHalf) begin
            r = {{16{d[15] & ~uns}}, d[15:0]};
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Any width other than BYTE/HALF is handled as WORD.
    always_comb begin
        misaligned = 1'b0;
        if (req_width == WidthHalf) begin
            misaligned = req_addr[0];
        end else if (req_width != WidthByte) begin
            misaligned = (req_addr[1:0] != 2'b00);
        end
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        width_d   = width_q;
        uns_d     = uns_q;
        wdata_d   = wdata_q;
        beat_d    = beat_q;
        result_d  = result_q;
        err_d     = err_q;
        lane      = result_q;
        last_beat = 1'b0;

        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_rdata   = 32'd0;
        rsp_error   = 1'b0;
        mem_valid   = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = addr_q;
        mem_width   = width_q;
        mem_data_wr = wdata_q;

        unique case (state_q)
            StIdle: begin
                req_ready = ~rst;
                if (req_valid) begin
                    we_d     = req_we;
                    addr_d   = req_addr;
                    width_d  = req_width;
                    uns_d    = req_unsigned;
                    wdata_d  = req_wdata;
                    beat_d   = 2'd0;
                    result_d = 32'd0;
                    err_d    = 1'b0;
                    if (!misaligned) begin
                        state_d = StAccess;
                    end else if (SPLIT_MISALIGNED != 0) begin
                        state_d = StSplit;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StAccess: begin
                mem_valid = 1'b1;
                mem_we    = we_q;
                if (!we_q) begin
                    result_d = extend(mem_data_rd, width_q, uns_q);
                end
                state_d = StResp;
            end
            StSplit: begin
                mem_valid   = 1'b1;
                mem_we      = we_q;
                mem_addr    = addr_q + {30'd0, beat_q};
                mem_width   = WidthByte;
                mem_data_wr = {24'd0, wdata_q[{beat_q, 3'b000} +: 8]};
                // Raw bytes accumulate in result_q; extension happens on the last beat.
                lane[{beat_q, 3'b000} +: 8] = mem_data_rd[7:0];
                last_beat = (width_q == WidthHalf) ? (beat_q == 2'd1) : (beat_q == 2'd3);
                if (last_beat) begin
                    result_d = we_q ? 32'd0 : extend(lane, width_q, uns_q);
                    state_d  = StResp;
                end else begin
                    result_d = we_q ? result_q : lane;
                    beat_d   = beat_q + 2'd1;
                end
            end
            StResp: begin
                rsp_valid = 1'b1;
                rsp_rdata = result_q;
                rsp_error = err_q;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            width_q  <= WidthByte;
            uns_q    <= 1'b0;
            wdata_q  <= 32'd0;
            beat_q   <= 2'd0;
            result_q <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            width_q  <= width_d;
            uns_q    <= uns_d;
            wdata_q  <= wdata_d;
            beat_q   <= beat_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_port_initiator.sv
// Directed bench for mem_port_initiator: a splitting instance backed by a byte-array responder
// and a rejecting instance backed by a constant read value.
module tb_mem_port_initiator;

    localparam logic [1:0] BYTE = 2'd0;
    localparam logic [1:0] HALF = 2'd1;
    localparam logic [1:0] WORD = 2'd2;

    logic        clk;
    logic        rst;
    logic        mem_init;
    logic        req_valid, rj_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_width;
    logic        req_unsigned;
    logic [31:0] req_wdata;

    logic        req_ready, rsp_valid, rsp_error;
    logic [31:0] rsp_rdata;
    logic        mem_valid, mem_we;
    logic [31:0] mem_addr, mem_data_wr, mem_data_rd;
    logic [1:0]  mem_width;

    logic        rj_ready, rj_rsp_valid, rj_rsp_error;
    logic [31:0] rj_rsp_rdata;
    logic        rj_mem_valid, rj_mem_we;
    logic [31:0] rj_mem_addr, rj_mem_data_wr;
    logic [1:0]  rj_mem_width;

    int checks = 0;
    int failures = 0;

    mem_port_initiator #(.SPLIT_MISALIGNED(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_width(req_width), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_width(mem_width),
        .mem_data_wr(mem_data_wr), .mem_data_rd(mem_data_rd)
    );

    mem_port_initiator #(.SPLIT_MISALIGNED(0)) dut_rj (
        .clk(clk), .rst(rst),
        .req_valid(rj_valid), .req_ready(rj_ready), .req_we(req_we), .req_addr(req_addr),
        .req_width(req_width), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .rsp_valid(rj_rsp_valid), .rsp_rdata(rj_rsp_rdata), .rsp_error(rj_rsp_error),
        .mem_valid(rj_mem_valid), .mem_we(rj_mem_we), .mem_addr(rj_mem_addr),
        .mem_width(rj_mem_width), .mem_data_wr(rj_mem_data_wr), .mem_data_rd(32'hDEAD_BEEF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-addressed responder, 256 bytes, combinational read, little-endian.
    logic [7:0] mem [256];
    logic [7:0] a0, a1, a2, a3;
    assign a0 = mem_addr[7:0];
    assign a1 = a0 + 8'd1;
    assign a2 = a0 + 8'd2;
    assign a3 = a0 + 8'd3;
    assign mem_data_rd = {mem[a3], mem[a2], mem[a1], mem[a0]};

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (mem_valid && mem_we) begin
            mem[a0] <= mem_data_wr[7:0];
            if (mem_width != BYTE) mem[a1] <= mem_data_wr[15:8];
            if (mem_width == WORD) begin
                mem[a2] <= mem_data_wr[23:16];
                mem[a3] <= mem_data_wr[31:24];
            end
        end
    end

    // Beat log of every cycle with mem_valid, sampled mid-cycle.
    logic [31:0] log_addr [256];
    logic [31:0] log_data [256];
    logic [1:0]  log_width [256];
    logic [7:0]  log_n = 8'd0;
    int          rj_beats = 0;

    always @(negedge clk) begin
        if (mem_valid) begin
            log_addr[log_n]  = mem_addr;
            log_data[log_n]  = mem_data_wr;
            log_width[log_n] = mem_width;
            log_n = log_n + 8'd1;
        end
        if (rj_mem_valid) rj_beats++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [1:0] w,
                         input logic uns, input logic [31:0] wd);
        req_we       = we;
        req_addr     = addr;
        req_width    = w;
        req_unsigned = uns;
        req_wdata    = wd;
        req_valid    = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge of the first cycle after acceptance.
    task automatic wait_accept(input string tag, input logic hold);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, " accept"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int exp_lat, input logic [31:0] exp_data);
        int lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, " rdata"}, rsp_rdata, exp_data);
        check_eq({tag, " error"}, 32'(rsp_error), 32'd0);
    endtask

    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [1:0] w, input logic uns, input logic [31:0] wd,
                        input int exp_lat, input logic [31:0] exp_data);
        drive(we, addr, w, uns, wd);
        wait_accept(tag, 1'b0);
        wait_rsp(tag, exp_lat, exp_data);
    endtask

    initial begin
        logic [7:0] s;
        int         viol;
        int         lat;
        int         rj0;

        rst = 1'b1;
        mem_init = 1'b1;
        req_valid = 1'b0;
        rj_valid = 1'b0;
        req_we = 1'b0;
        req_addr = 32'd0;
        req_width = BYTE;
        req_unsigned = 1'b0;
        req_wdata = 32'd0;

        repeat (3) @(negedge clk);
        check_eq("rst req_ready", 32'(req_ready), 32'd0);
        check_eq("rst mem_valid", 32'(mem_valid), 32'd0);
        check_eq("rst mem_we", 32'(mem_we), 32'd0);
        check_eq("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst rsp_rdata", rsp_rdata, 32'd0);
        check_eq("rst rsp_error", 32'(rsp_error), 32'd0);
        check_eq("rst rj req_ready", 32'(rj_ready), 32'd0);
        rst = 1'b0;
        mem_init = 1'b0;
        @(negedge clk);
        check_eq("idle req_ready", 32'(req_ready), 32'd1);

        // Reset in beat 2 of a split WORD store at 1: bytes 1,2 committed, 3,4 untouched.
        drive(1'b1, 32'd1, WORD, 1'b0, 32'h4433_2211);
        wait_accept("rst_split", 1'b0);
        @(negedge clk);
        check_eq("rst_split beat2 addr", mem_addr, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_split valid dropped", 32'(mem_valid), 32'd0);
        check_eq("rst_split no rsp", 32'(rsp_valid), 32'd0);
        check_eq("rst_split ready in rst", 32'(req_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_split ready after", 32'(req_ready), 32'd1);
        check_eq("rst_split no rsp after", 32'(rsp_valid), 32'd0);
        check_eq("rst_split byte1", 32'(mem[1]), 32'h11);
        check_eq("rst_split byte2", 32'(mem[2]), 32'h22);
        check_eq("rst_split byte3", 32'(mem[3]), 32'h00);
        check_eq("rst_split byte4", 32'(mem[4]), 32'h00);

        // Aligned accesses and extension.
        xact("st_w8", 1'b1, 32'd8, WORD, 1'b0, 32'h8765_4321, 2, 32'h0);
        xact("ld_w8", 1'b0, 32'd8, WORD, 1'b0, 32'h0, 2, 32'h8765_4321);
        xact("ld_b9", 1'b0, 32'd9, BYTE, 1'b0, 32'h0, 2, 32'h0000_0043);
        xact("ld_h10", 1'b0, 32'd10, HALF, 1'b0, 32'h0, 2, 32'hFFFF_8765);
        xact("st_b3", 1'b1, 32'd3, BYTE, 1'b0, 32'h0000_0080, 2, 32'h0);
        xact("ld_b3s", 1'b0, 32'd3, BYTE, 1'b0, 32'h0, 2, 32'hFFFF_FF80);
        xact("ld_b3u", 1'b0, 32'd3, BYTE, 1'b1, 32'h0, 2, 32'h0000_0080);

        // Split store WORD at 5: four BYTE beats to 5..8.
        s = log_n;
        xact("st_w5", 1'b1, 32'd5, WORD, 1'b0, 32'hDDCC_BBAA, 5, 32'h0);
        check_eq("st_w5 beats", 32'(log_n - s), 32'd4);
        for (int k = 0; k < 4; k++) begin
            logic [7:0] idx;
            logic [7:0] exp_b;
            idx = s + 8'(k);
            exp_b = 8'hAA + 8'(k * 8'h11);
            check_eq($sformatf("st_w5 addr%0d", k), log_addr[idx], 32'(5 + k));
            check_eq($sformatf("st_w5 data%0d", k), 32'(log_data[idx][7:0]), 32'(exp_b));
            check_eq($sformatf("st_w5 width%0d", k), 32'(log_width[idx]), 32'(BYTE));
        end
        xact("ld_w5", 1'b0, 32'd5, WORD, 1'b0, 32'h0, 5, 32'hDDCC_BBAA);
        xact("ld_h7s", 1'b0, 32'd7, HALF, 1'b0, 32'h0, 3, 32'hFFFF_DDCC);
        xact("ld_h7u", 1'b0, 32'd7, HALF, 1'b1, 32'h0, 3, 32'h0000_DDCC);

        // Held request while busy: ready stays low, then the held load completes.
        drive(1'b0, 32'd5, WORD, 1'b0, 32'h0);
        wait_accept("hs", 1'b1);
        req_addr = 32'd8;
        viol = 0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            if (req_ready) viol++;
            @(negedge clk);
            lat++;
        end
        if (req_ready) viol++;
        check_eq("hs first latency", 32'(lat), 32'd5);
        check_eq("hs first rdata", rsp_rdata, 32'hDDCC_BBAA);
        check_eq("hs ready low while busy", 32'(viol), 32'd0);
        wait_accept("hs second", 1'b0);
        wait_rsp("hs second", 2, 32'h8765_43DD);

        // Rejecting instance: misaligned HALF load errors at N+1 with no memory beat.
        @(negedge clk);
        req_we = 1'b0;
        req_addr = 32'd1;
        req_width = HALF;
        req_unsigned = 1'b0;
        rj_valid = 1'b1;
        rj0 = rj_beats;
        check_eq("rj ready", 32'(rj_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rj_valid = 1'b0;
        check_eq("rj rsp_valid", 32'(rj_rsp_valid), 32'd1);
        check_eq("rj rsp_error", 32'(rj_rsp_error), 32'd1);
        check_eq("rj rsp_rdata", rj_rsp_rdata, 32'd0);
        @(negedge clk);
        check_eq("rj rsp one cycle", 32'(rj_rsp_valid), 32'd0);
        check_eq("rj no mem beats", 32'(rj_beats - rj0), 32'd0);
        // An aligned load on the same instance still reaches memory.
        req_addr = 32'd0;
        req_width = WORD;
        rj_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rj_valid = 1'b0;
        check_eq("rj aligned access", 32'(rj_mem_valid), 32'd1);
        @(negedge clk);
        check_eq("rj aligned rsp", 32'(rj_rsp_valid), 32'd1);
        check_eq("rj aligned rdata", rj_rsp_rdata, 32'hDEAD_BEEF);
        check_eq("rj aligned error", 32'(rj_rsp_error), 32'd0);

        // Address wrap on a split WORD store and load.
        s = log_n;
        xact("st_wrap", 1'b1, 32'hFFFF_FFFE, WORD, 1'b0, 32'h1122_3344, 5, 32'h0);
        check_eq("st_wrap addr0", log_addr[s], 32'hFFFF_FFFE);
        check_eq("st_wrap addr1", log_addr[s + 8'd1], 32'hFFFF_FFFF);
        check_eq("st_wrap addr2", log_addr[s + 8'd2], 32'h0000_0000);
        check_eq("st_wrap addr3", log_addr[s + 8'd3], 32'h0000_0001);
        check_eq("st_wrap data3", 32'(log_data[s + 8'd3][7:0]), 32'h11);
        xact("ld_wrap", 1'b0, 32'hFFFF_FFFE, WORD, 1'b0, 32'h0, 5, 32'h1122_3344);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_initiator.md
# mem_port_initiator

Initiator side of `memory_port`: accepts one load/store request at a time from the core and drives `valid/we/addr/width/data_wr` toward a `memory_vcomp`-style responder. It returns load data extended to 32 bits. Misaligned HALF/WORD accesses are either split into little-endian BYTE beats or rejected, selected by parameter. It sits between the core's execute stage and the data memory port.

## Interface
- `SPLIT_MISALIGNED`, default 1: 1 = split misaligned accesses into BYTE beats; 0 = reject them with `rsp_error`.
- `clk` in 1: clock; every register updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in 1: a request is presented.
- `req_ready` out 1: the block can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_width` in `memory_access_width_t`: BYTE, HALF or WORD.
- `req_unsigned` in 1: for loads, 1 = zero-extend, 0 = sign-extend. Ignored for WORD.
- `req_wdata` in 32: store data, taken from the low bytes.
- `rsp_valid` out 1: one-cycle pulse that completes a request.
- `rsp_rdata` out 32: extended load data. It is 0 for stores and for errors.
- `rsp_error` out 1: marks a rejected misaligned access. Only meaningful when `rsp_valid` is 1.
- `mem_port` `memory_port` initiator: drives `valid`, `we`, `addr`, `width`, `data_wr`; samples `data_rd`.

## Operation
- FSM states: IDLE, ACCESS, SPLIT, RESP.
- Alignment rule: HALF is aligned when `addr[0]` = 0. WORD is aligned when `addr[1:0]` = 0. BYTE is always aligned.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, latch `we`, `addr`, `width`, `unsigned`, `wdata`.
  - Aligned request goes to ACCESS.
  - Misaligned request with `SPLIT_MISALIGNED`=1 goes to SPLIT, with beat counter = 0.
  - Misaligned request with `SPLIT_MISALIGNED`=0 goes to RESP with the error flag set.
- ACCESS (one cycle):
  - Port outputs: `valid`=1, `we`=latched, `addr`=latched, `width`=latched, `data_wr`=latched wdata.
  - Load: capture `data_rd` at the closing edge, then extend (BYTE from bit 7, HALF from bit 15, unless unsigned).
  - Next state is RESP.
- SPLIT (2 beats for HALF, 4 for WORD):
  - Beat k drives `valid`=1, `width`=BYTE, `addr` = latched addr + k (mod 2^32), `data_wr[7:0]` = wdata[8k+7:8k].
  - Load: `data_rd[7:0]` is captured into result byte lane k.
  - After the last beat, extend the result as in ACCESS and go to RESP.
- RESP (one cycle):
  - `rsp_valid`=1, `rsp_rdata`=result (0 for store or error), `rsp_error`=flag.
  - Next state is IDLE.
- `req_ready`=0 in every state except IDLE, and while `rst` is high.
- `mem_port.valid`=0 in IDLE and RESP. `we` and `width` are don't-care when `valid`=0.
- No response backpressure: the consumer must take `rsp_*` in the cycle it is asserted.

## Timing
- Reset values, starting the cycle after the edge that samples `rst`=1:
  - state = IDLE, `mem_port.valid`=0, `mem_port.we`=0.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_error`=0, `req_ready`=0 while `rst`=1.
- Latency, with the request accepted at edge N (the cycle before N+1):
  - Aligned: memory access in cycle N+1, `rsp_valid` in cycle N+2.
  - Misaligned HALF: beats in N+1 and N+2, response in N+3.
  - Misaligned WORD: beats in N+1 through N+4, response in N+5.
  - Rejected request: response in N+1, and no memory access is made.
- Loads rely on the combinational read of the responder: `data_rd` is valid within the same cycle as `valid`.
- Stores commit at the edge that closes each cycle with `valid`=1 and `we`=1.
- Back-to-back: a new request can be accepted in the cycle after RESP, so throughput is one aligned request per 3 cycles.
- Reset mid-operation:
  - The FSM returns to IDLE and `valid` drops in the next cycle.
  - Store beats already committed stay in memory, so a partial store is possible.
  - No `rsp_valid` is issued for the aborted request.
- Address wrap: a split access at 0xFFFF_FFFE with WORD width uses byte addresses FFFE, FFFF, 0000, 0001.
- `req_valid` while not in IDLE is ignored; the requester must hold it until `req_ready`.

## Test plan
- Reset, then aligned store WORD 0x8765_4321 at addr 8, then load WORD at 8 → `rsp_rdata`=0x8765_4321 two cycles after acceptance. Loads of BYTE at 9 (signed) → 0x0000_0043; HALF at 10 (signed) → 0xFFFF_8765.
- Extension: store BYTE 0x80 at 3. Load signed BYTE at 3 → 0xFFFF_FF80; unsigned → 0x0000_0080.
- Split (`SPLIT_MISALIGNED`=1): store WORD 0xDDCC_BBAA at 5 → exactly 4 BYTE beats to addrs 5–8 with data AA, BB, CC, DD. Load WORD at 5 → 0xDDCC_BBAA, with `rsp_valid` at N+5.
- Reject (`SPLIT_MISALIGNED`=0): load HALF at 1 → `rsp_valid` with `rsp_error`=1 and `rdata`=0 at N+1; `mem_port.valid` is never asserted.
- Reset during SPLIT store WORD 0x4433_2211 at 1, asserted in beat 2:
  - Bytes 1 and 2 hold 0x11 and 0x22; bytes 3 and 4 are unchanged.
  - No `rsp_valid`; `req_ready`=1 in the cycle after `rst` deasserts.
- Handshake: hold `req_valid` with a new load during an in-flight request → not accepted until IDLE, then it completes with correct data; `req_ready` low throughout the busy period.
